// File: rtl/uart_tx.sv
// Serial UART transmitter: start bit, LSB-first data, optional parity, stop bit.
// TX_OUT and BUSY are registered; BUSY rises exactly once per frame.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_nxt;
    logic                  parity_bit;

    assign cnt_nxt    = cnt_q + CntW'(1);
    assign parity_bit = (^data_q) ^ par_typ_q;

    // Each output register is loaded with the value of the state being entered,
    // so the line level always matches the current state without a comb path.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (DATA_VALID) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        state_q   <= StStart;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                    end else begin
                        TX_OUT <= 1'b1;
                        BUSY   <= 1'b0;
                    end
                end
                StStart: begin
                    state_q <= StData;
                    cnt_q   <= '0;
                    TX_OUT  <= data_q[0];
                    BUSY    <= 1'b1;
                end
                StData: begin
                    BUSY <= 1'b1;
                    if (cnt_q == LastBit) begin
                        cnt_q <= '0;
                        if (par_en_q) begin
                            state_q <= StParity;
                            TX_OUT  <= parity_bit;
                        end else begin
                            state_q <= StStop;
                            TX_OUT  <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_nxt;
                        TX_OUT <= data_q[cnt_nxt];
                    end
                end
                StParity: begin
                    state_q <= StStop;
                    cnt_q   <= '0;
                    TX_OUT  <= 1'b1;
                    BUSY    <= 1'b1;
                end
                StStop: begin
                    // Always pass through IDLE so BUSY drops for at least one cycle.
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    TX_OUT  <= 1'b1;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    TX_OUT  <= 1'b1;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames plus back-to-back, mid-frame
// disturbance and asynchronous reset sequences.
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    int errors = 0;
    int checks = 0;
    int rises  = 0;
    logic busy_prev = 1'b0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count BUSY rising edges seen at sample points.
    always @(negedge CLK) begin
        if (BUSY && !busy_prev) rises++;
        busy_prev = BUSY;
    end

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        int          len;
        logic [0:10] seq;   // line level per frame cycle, in transmit order
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input logic act, input logic exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input int act, input int exp, input string name);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entered at the negedge just after the accepting edge; returns at the
    // negedge of the first IDLE cycle after the frame.
    task automatic check_frame(input logic [0:10] seq, input int len, input bit disturb,
                               input string name);
        for (int i = 0; i < len; i++) begin
            chk(TX_OUT, seq[i], $sformatf("%s tx[%0d]", name, i));
            chk(BUSY, 1'b1, $sformatf("%s busy[%0d]", name, i));
            if (disturb && i == 3) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'hFF;
                PAR_EN     = 1'b1;
            end
            if (disturb && i == 5) DATA_VALID = 1'b0;
            @(negedge CLK);
        end
        chk(TX_OUT, 1'b1, {name, " idle tx"});
        chk(BUSY, 1'b0, {name, " idle busy"});
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
    endtask

    int base;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b01010010111};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b01010010101};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'b01010010111};
        vecs[3] = '{8'h01, 1'b1, 1'b1, 11, 11'b01000000001};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 11, 11'b00000000001};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 10, 11'b00011110011};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 10, 11'b01100001111};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 11, 11'b01111111111};

        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        chk(TX_OUT, 1'b1, "reset tx");
        chk(BUSY, 1'b0, "reset busy");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk(TX_OUT, 1'b1, "post-reset tx");
        chk(BUSY, 1'b0, "post-reset busy");

        base = rises;
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            check_frame(vecs[v].seq, vecs[v].len, 1'b0, $sformatf("vec%0d", v));
        end
        chk_int(rises - base, 8, "table busy rises");

        // DATA_VALID held high: 3C then C3 with exactly one idle cycle between.
        base       = rises;
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hC3;
        check_frame(vecs[5].seq, 10, 1'b0, "b2b 3C");
        @(negedge CLK);
        DATA_VALID = 1'b0;
        check_frame(vecs[6].seq, 10, 1'b0, "b2b C3");
        @(negedge CLK);
        chk(BUSY, 1'b0, "b2b after busy");
        chk_int(rises - base, 2, "b2b busy rises");

        // Inputs toggled mid-frame must not alter the frame or start another.
        base = rises;
        send(8'hA5, 1'b0, 1'b0);
        check_frame(vecs[0].seq, 10, 1'b1, "disturb");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk(BUSY, 1'b0, $sformatf("disturb quiet busy[%0d]", i));
            chk(TX_OUT, 1'b1, $sformatf("disturb quiet tx[%0d]", i));
        end
        chk_int(rises - base, 1, "disturb busy rises");

        // Asynchronous reset during data bit 3 (line low for 0xA5).
        base = rises;
        send(8'hA5, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        chk(TX_OUT, 1'b0, "pre-abort tx bit3");
        chk(BUSY, 1'b1, "pre-abort busy");
        RST = 1'b0;
        #1;
        chk(TX_OUT, 1'b1, "abort tx immediate");
        chk(BUSY, 1'b0, "abort busy immediate");
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk(TX_OUT, 1'b1, $sformatf("after abort tx[%0d]", i));
            chk(BUSY, 1'b0, $sformatf("after abort busy[%0d]", i));
        end
        chk_int(rises - base, 1, "abort busy rises");

        send(8'h01, 1'b1, 1'b1);
        check_frame(vecs[3].seq, 11, 1'b0, "post-abort frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter. Converts a parallel byte into an asynchronous serial frame (start, data LSB-first, optional parity, stop) on one output line and raises a level BUSY for the whole frame. BUSY feeds directly into the pulse generator, which turns each BUSY rising edge into a single-cycle read-increment pulse for the TX FIFO. BUSY must therefore rise exactly once per frame and must never stay high across two frames.

## Interface

Parameters:
- DATA_WIDTH, default 8: number of data bits per frame.

Ports:
- CLK  input  1  transmit clock; one serial bit per cycle (already divided to the baud rate upstream).
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to send.
- DATA_VALID  input  1  request to send P_DATA; sampled only in IDLE.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idle/mark level is 1.
- BUSY  output  1  1 while a frame is on the line.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0. On a CLK edge with DATA_VALID=1, latch P_DATA, PAR_EN and PAR_TYP into internal registers and move to START.
- START: TX_OUT=0, BUSY=1. Next state is DATA with bit counter = 0.
- DATA: TX_OUT = latched_data[counter], LSB first. The counter increments each cycle. After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = XOR-reduce(latched_data) XOR latched PAR_TYP. Even parity makes the total count of 1s (data plus parity) even; odd parity makes it odd. Next state is STOP.
- STOP: TX_OUT=1, BUSY=1. Next state is always IDLE. There is no direct STOP→START path, even if DATA_VALID=1.
- DATA_VALID, P_DATA, PAR_EN and PAR_TYP are ignored outside IDLE. Changing them mid-frame has no effect on the current frame.
- The counter width is clog2(DATA_WIDTH). The counter is held at 0 outside DATA.
- TX_OUT and BUSY are registered outputs, with no combinational path from the inputs, so the line is glitch-free.

## Timing

- Reset (RST=0, asynchronous): the state goes to IDLE immediately, TX_OUT=1, BUSY=0, and the latched data, parity config and counter are cleared to 0.
- Reset mid-frame: the frame is aborted at once and the line returns to mark (1). Nothing resumes after reset is released; a new DATA_VALID is required.
- Acceptance latency: if DATA_VALID=1 is sampled in IDLE at edge k, then TX_OUT=0 and BUSY=1 are visible after edge k.
- Frame length is 2+DATA_WIDTH cycles without parity and 3+DATA_WIDTH cycles with parity, i.e. 10 or 11 cycles for the default width. BUSY is high for exactly this many cycles.
- After STOP there is a mandatory minimum of 1 IDLE cycle (BUSY=0, TX_OUT=1). This guarantees one BUSY rising edge per frame for the downstream pulse generator.
- DATA_VALID held continuously high: frames repeat with a period of frame length + 1 cycles.
- DATA_VALID asserted during STOP: it is not accepted at that edge. It is accepted at the edge that ends the following IDLE cycle, provided it is still high.

## Test plan

- Reset, then DATA_VALID pulsed one cycle with P_DATA=0xA5 and PAR_EN=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. BUSY=1 for exactly 10 cycles, then 0.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 and an 11-cycle frame. Same data with PAR_TYP=1 -> parity bit 1.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0. P_DATA=0x00 with even parity -> parity bit 0.
- DATA_VALID held high with P_DATA=0x3C, 0xC3 and PAR_EN=0 -> two back-to-back frames separated by exactly one cycle of BUSY=0/TX_OUT=1. Exactly two BUSY rising edges.
- Mid-frame, toggle DATA_VALID and change P_DATA to 0xFF -> the transmitted bits still match the originally latched byte and no extra frame starts.
- RST driven low during the 4th data bit -> TX_OUT=1 and BUSY=0 immediately, without waiting for a clock edge. After release the line stays idle until a new DATA_VALID.
